// File: rtl/vga_pkg.sv
// Shared VGA constants and types for the display controller and the pixel fetcher.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } fetch_state_t;

endpackage

// File: rtl/vga_pixel_fetcher_if.sv
// Pixel request/colour path and frame-memory read port of the pixel fetcher.
interface vga_pixel_fetcher_if #(
    parameter int ADDR_W = 19
);

    logic [9:0]        inX;
    logic [9:0]        inY;
    logic              inRequest;
    logic [7:0]        outRed;
    logic [7:0]        outGreen;
    logic [7:0]        outBlue;
    logic              memReq;
    logic [ADDR_W-1:0] memAddr;
    logic              memAck;
    logic [23:0]       memData;
    logic              underrun;

    modport slave (
        input  inX, inY, inRequest, memAck, memData,
        output outRed, outGreen, outBlue, memReq, memAddr, underrun
    );

    modport master (
        output inX, inY, inRequest, memAck, memData,
        input  outRed, outGreen, outBlue, memReq, memAddr, underrun
    );

endinterface

// File: rtl/line_buffer_2p.sv
// Two-bank line RAM: one write port for the fill side, one synchronous read port for display.
module line_buffer_2p #(
    parameter int H_ACTIVE = 640,
    localparam int COL_W = $clog2(H_ACTIVE)
) (
    input  logic               clk25,
    input  logic               wr_en,
    input  logic               wr_bank,
    input  logic [COL_W-1:0]   wr_col,
    input  vga_pkg::rgb_t      wr_data,
    input  logic               rd_bank,
    input  logic [COL_W-1:0]   rd_col,
    output vga_pkg::rgb_t      rd_data
);
    import vga_pkg::*;

    localparam int DEPTH = 2 * H_ACTIVE;
    localparam int IDX_W = $clog2(DEPTH);

    rgb_t             mem [DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    // {bank, column} packed densely: bank 1 starts right after the last column of bank 0
    assign wr_idx = wr_bank ? IDX_W'(H_ACTIVE) + IDX_W'(wr_col) : IDX_W'(wr_col);
    assign rd_idx = rd_bank ? IDX_W'(H_ACTIVE) + IDX_W'(rd_col) : IDX_W'(rd_col);

    always_ff @(posedge clk25) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        rd_data <= mem[rd_idx];
    end

endmodule

// File: rtl/vga_pixel_fetcher.sv
// Pixel source for the VGA controller: ping-pong line buffers filled one line ahead from frame memory.
//   state | meaning
//   IDLE  | waiting for a line trigger
//   FETCH | memReq high, one word stored per memAck
//   DONE  | one cycle with memReq low before the next fetch
module vga_pixel_fetcher #(
    parameter int H_ACTIVE  = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE  = vga_pkg::V_ACTIVE,
    parameter int ADDR_W    = 19,
    parameter int BASE_ADDR = 0
) (
    input logic                clk25,
    input logic                rstN,
    vga_pixel_fetcher_if.slave bus
);
    import vga_pkg::*;

    localparam int                COL_W     = $clog2(H_ACTIVE);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [9:0]        LAST_LINE = 10'(V_ACTIVE - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(H_ACTIVE - 1);

    fetch_state_t      state;
    fetch_state_t      state_nx;
    logic [1:0]        bank_valid;
    logic              line_ok;
    logic              show;
    logic              underrun_q;
    logic              prime;
    logic              pend_valid;
    logic [9:0]        pend_line;
    logic              fill_bank;
    logic [COL_W-1:0]  count;
    logic [ADDR_W-1:0] addr;
    rgb_t              rd_data;

    logic              line_start;
    logic              trig;
    logic [9:0]        trig_line;
    logic [9:0]        next_line;
    logic [9:0]        start_line;
    logic              start_fetch;
    logic              word_wr;
    logic              fill_done;
    logic              pend_set;
    logic              bank_ok;

    assign line_start = bus.inRequest && (bus.inX == 10'd0);
    assign next_line  = (bus.inY == LAST_LINE) ? 10'd0 : bus.inY + 10'd1;
    assign trig       = line_start || prime;
    assign trig_line  = line_start ? next_line : 10'd0;

    always_ff @(posedge clk25) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        start_fetch = 1'b0;
        start_line  = trig ? trig_line : pend_line;
        word_wr     = 1'b0;
        fill_done   = 1'b0;
        pend_set    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (trig || pend_valid) begin
                    start_fetch = 1'b1;
                    state_nx    = FETCH;
                end else begin
                    state_nx = IDLE;
                end
            end
            FETCH: begin
                pend_set = trig;
                if (bus.memAck) begin
                    word_wr = 1'b1;
                    if (count == LAST_COL) begin
                        fill_done = 1'b1;
                        state_nx  = DONE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk25) begin
        if (!rstN) begin
            addr       <= BASE;
            count      <= '0;
            fill_bank  <= 1'b0;
            pend_valid <= 1'b0;
            pend_line  <= '0;
            prime      <= 1'b1;
        end else begin
            prime <= 1'b0;
            if (start_fetch) begin
                addr       <= BASE + ADDR_W'(start_line) * ADDR_W'(H_ACTIVE);
                count      <= '0;
                fill_bank  <= start_line[0];
                pend_valid <= 1'b0;
            end else if (word_wr) begin
                addr  <= addr + ADDR_W'(1);
                count <= count + COL_W'(1);
            end
            // a newer trigger simply replaces whatever is waiting
            if (pend_set) begin
                pend_valid <= 1'b1;
                pend_line  <= trig_line;
            end
        end
    end

    // a fill finishing in the same cycle as its line start still counts as ready
    assign bank_ok = bank_valid[bus.inY[0]] || (fill_done && (fill_bank == bus.inY[0]));

    always_ff @(posedge clk25) begin
        if (!rstN) begin
            bank_valid <= '0;
            line_ok    <= 1'b0;
            show       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (fill_done) begin
                bank_valid[fill_bank] <= 1'b1;
            end
            if (line_start) begin
                bank_valid[bus.inY[0]] <= 1'b0;
                line_ok                <= bank_ok;
                if (!bank_ok) begin
                    underrun_q <= 1'b1;
                end
            end
            show <= bus.inRequest && (line_start ? bank_ok : line_ok);
        end
    end

    line_buffer_2p #(
        .H_ACTIVE (H_ACTIVE)
    ) u_line_buffer (
        .clk25   (clk25),
        .wr_en   (word_wr),
        .wr_bank (fill_bank),
        .wr_col  (count),
        .wr_data (bus.memData),
        .rd_bank (bus.inY[0]),
        .rd_col  (bus.inX[COL_W-1:0]),
        .rd_data (rd_data)
    );

    assign bus.memReq   = (state == FETCH);
    assign bus.memAddr  = addr;
    assign bus.underrun = underrun_q;
    assign bus.outRed   = show ? rd_data.r : 8'd0;
    assign bus.outGreen = show ? rd_data.g : 8'd0;
    assign bus.outBlue  = show ? rd_data.b : 8'd0;

endmodule

// File: tb/tb_vga_pixel_fetcher.sv
// Directed bench for vga_pixel_fetcher; the frame memory returns its own word address as data.
module tb_vga_pixel_fetcher;

    logic clk25 = 1'b0;
    logic rstN;
    int   total = 0;
    int   bad   = 0;
    int   ack_mode = 0;

    vga_pixel_fetcher_if #(.ADDR_W(19)) bus ();

    vga_pixel_fetcher dut (
        .clk25 (clk25),
        .rstN  (rstN),
        .bus   (bus)
    );

    always #20 clk25 = ~clk25;

    assign bus.memData = {5'd0, bus.memAddr};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ra(input logic r, input int a);
        return {12'd0, r, a[18:0]};
    endfunction

    function automatic logic [31:0] obs_ra();
        return {12'd0, bus.memReq, bus.memAddr};
    endfunction

    function automatic logic [31:0] obs_rgb();
        return {8'd0, bus.outRed, bus.outGreen, bus.outBlue};
    endfunction

    task automatic tick();
        @(posedge clk25);
        #1;
        if (ack_mode == 1) bus.memAck = ~bus.memAck;
    endtask

    task automatic pix(input logic req, input int y, input int x);
        bus.inRequest = req;
        bus.inY       = 10'(y);
        bus.inX       = 10'(x);
    endtask

    initial begin
        int drops;
        int found;

        rstN          = 1'b0;
        bus.memAck    = 1'b0;
        pix(1'b0, 0, 0);
        repeat (3) tick();
        check("rst_req_addr", obs_ra(), ra(1'b0, 0));
        check("rst_rgb", obs_rgb(), 32'h0);
        check("rst_underrun", 32'(bus.underrun), 32'h0);

        // priming fetch of line 0, memory acks every cycle
        bus.memAck = 1'b1;
        rstN       = 1'b1;
        tick();
        check("prime_start", obs_ra(), ra(1'b1, 0));
        for (int i = 1; i < 640; i++) begin
            tick();
            check("prime_fetch", obs_ra(), ra(1'b1, i));
        end
        tick();
        check("prime_end", obs_ra(), ra(1'b0, 640));

        // line 0 display, fetch of line 1
        pix(1'b1, 0, 0);
        tick();
        check("l0_start_fetch", obs_ra(), ra(1'b1, 640));
        check("l0_x0", obs_rgb(), 32'h000000);
        pix(1'b1, 0, 5);
        tick();
        check("l0_x5", obs_rgb(), 32'h000005);
        pix(1'b1, 0, 300);
        tick();
        check("l0_x300", obs_rgb(), 32'h00012C);
        pix(1'b1, 0, 639);
        tick();
        check("l0_x639", obs_rgb(), 32'h00027F);

        // blanking with arbitrary position: black, no new fetch
        pix(1'b0, 7, 0);
        tick();
        check("blank_rgb", obs_rgb(), 32'h0);
        repeat (700) tick();
        check("blank_no_fetch", obs_ra(), ra(1'b0, 1280));
        check("blank_rgb_late", obs_rgb(), 32'h0);

        // line 1 from bank 1
        pix(1'b1, 1, 0);
        tick();
        check("l1_start_fetch", obs_ra(), ra(1'b1, 1280));
        check("l1_x0", obs_rgb(), 32'h000280);
        pix(1'b1, 1, 10);
        tick();
        check("l1_x10", obs_rgb(), 32'h00028A);
        check("l1_underrun", 32'(bus.underrun), 32'h0);
        pix(1'b0, 1, 20);
        repeat (700) tick();

        // end of frame: 478 -> fetch 479, 479 -> fetch wraps to line 0
        pix(1'b1, 478, 0);
        tick();
        check("l478_fetch", obs_ra(), ra(1'b1, 306560));
        check("l478_x0", obs_rgb(), 32'h000500);
        pix(1'b0, 478, 0);
        repeat (700) tick();
        pix(1'b1, 479, 0);
        tick();
        check("l479_wrap_fetch", obs_ra(), ra(1'b1, 0));
        check("l479_x0", obs_rgb(), 32'h04AD80);
        pix(1'b1, 479, 3);
        tick();
        check("l479_x3", obs_rgb(), 32'h04AD83);
        pix(1'b0, 479, 0);
        repeat (700) tick();
        pix(1'b1, 0, 0);
        tick();
        check("f2_l0_fetch", obs_ra(), ra(1'b1, 640));
        pix(1'b1, 0, 7);
        tick();
        check("f2_l0_x7", obs_rgb(), 32'h000007);
        check("f2_underrun", 32'(bus.underrun), 32'h0);
        pix(1'b0, 0, 0);
        repeat (700) tick();

        // slow memory: ack every 2nd cycle, next line start beats the fill
        ack_mode   = 1;
        bus.memAck = 1'b0;
        pix(1'b1, 1, 0);
        tick();
        check("slow_fetch", obs_ra(), ra(1'b1, 1280));
        check("slow_l1_x0", obs_rgb(), 32'h000280);
        pix(1'b0, 1, 0);
        drops = 0;
        repeat (799) begin
            tick();
            if (bus.memReq !== 1'b1) drops++;
        end
        check("slow_req_held", 32'(drops), 32'h0);
        pix(1'b1, 2, 0);
        tick();
        check("ur_x0", obs_rgb(), 32'h0);
        check("ur_flag", 32'(bus.underrun), 32'h1);
        check("ur_req_held", 32'(bus.memReq), 32'h1);
        pix(1'b1, 2, 5);
        tick();
        check("ur_x5", obs_rgb(), 32'h0);
        pix(1'b0, 2, 0);
        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            tick();
            if (bus.memReq === 1'b0) found = 1;
        end
        check("ur_fill_end_seen", 32'(found), 32'h1);
        check("ur_fill_end_addr", obs_ra(), ra(1'b0, 1920));
        tick();
        check("pend_fetch", obs_ra(), ra(1'b1, 1920));
        check("ur_sticky", 32'(bus.underrun), 32'h1);

        // reset in the middle of the line-3 fetch at word 300
        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            if (bus.memAddr === 19'd2220) found = 1;
            else tick();
        end
        check("mid_fetch_reached", 32'(found), 32'h1);
        rstN = 1'b0;
        tick();
        check("mid_rst_req_addr", obs_ra(), ra(1'b0, 0));
        check("mid_rst_rgb", obs_rgb(), 32'h0);
        check("mid_rst_underrun", 32'(bus.underrun), 32'h0);
        repeat (2) tick();
        check("mid_rst_late_ack", obs_ra(), ra(1'b0, 0));
        rstN = 1'b1;
        tick();
        check("reprime", obs_ra(), ra(1'b1, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
